// File: rtl/lift_car_sequencer.sv
// lift_car_sequencer: timed car model producing floor one-hot, door level and limit errors
module lift_car_sequencer #(
  parameter int N_FLOORS           = 8,
  parameter int TRAVEL_CYCLES      = 16,
  parameter int DOOR_OPEN_CYCLES   = 32,
  parameter int CLOSE_GUARD_CYCLES = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        i_motion,
  input  logic                        i_direction,
  input  logic                        i_has_rqst_at_stopped_flr,
  input  logic                        i_door_hold,
  output logic [N_FLOORS-1:0]         o_flr_pos,
  output logic                        o_door_open,
  output logic [$clog2(N_FLOORS)-1:0] o_floor_idx,
  output logic                        o_limit_err
);
  localparam int FW = $clog2(N_FLOORS);
  localparam int M1 = TRAVEL_CYCLES > DOOR_OPEN_CYCLES ? TRAVEL_CYCLES : DOOR_OPEN_CYCLES;
  localparam int MAX_T = M1 > CLOSE_GUARD_CYCLES ? M1 : CLOSE_GUARD_CYCLES;
  localparam int TW = $clog2(MAX_T) + 1;
  typedef enum logic [1:0] {PARKED, TRAVEL, DOOR_OPEN, CLOSE_GUARD} state_t;
  state_t state, state_n;
  logic [TW-1:0] timer, timer_n;
  logic [FW-1:0] floor_n;
  logic dir, dir_n, err_n, at_top, at_bot;
  assign at_top = o_floor_idx == FW'(N_FLOORS - 1);
  assign at_bot = o_floor_idx == '0;
  // next state, shared timer, floor and limit-error decisions
  always_comb begin
    state_n = state;
    timer_n = timer;
    floor_n = o_floor_idx;
    dir_n   = dir;
    err_n   = 1'b0;
    case (state)
      PARKED:
        if (i_has_rqst_at_stopped_flr) begin
          state_n = DOOR_OPEN;
          timer_n = TW'(DOOR_OPEN_CYCLES - 1);
        end else if (i_motion) begin
          if (i_direction ? at_top : at_bot) err_n = 1'b1;
          else begin
            state_n = TRAVEL;
            timer_n = TW'(TRAVEL_CYCLES - 1);
            dir_n   = i_direction;
          end
        end
      TRAVEL:
        if (timer == '0) begin
          state_n = PARKED;
          floor_n = dir ? o_floor_idx + 1'b1 : o_floor_idx - 1'b1;
        end else timer_n = timer - 1'b1;
      DOOR_OPEN:
        if (i_door_hold) timer_n = TW'(DOOR_OPEN_CYCLES - 1);
        else if (timer == '0) begin
          state_n = CLOSE_GUARD;
          timer_n = TW'(CLOSE_GUARD_CYCLES - 1);
        end else timer_n = timer - 1'b1;
      CLOSE_GUARD:
        if (timer == '0) state_n = PARKED;
        else timer_n = timer - 1'b1;
      default: state_n = PARKED;
    endcase
  end
  // state and registered outputs derived from the next state
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= PARKED;
      timer       <= '0;
      dir         <= 1'b0;
      o_flr_pos   <= N_FLOORS'(1);
      o_door_open <= 1'b0;
      o_floor_idx <= '0;
      o_limit_err <= 1'b0;
    end else begin
      state       <= state_n;
      timer       <= timer_n;
      dir         <= dir_n;
      o_flr_pos   <= state_n == TRAVEL ? '0 : N_FLOORS'(1) << floor_n;
      o_door_open <= state_n == DOOR_OPEN;
      o_floor_idx <= floor_n;
      o_limit_err <= err_n;
    end
  end
  // output invariants: position one-hot or empty, door only open at a floor, floor in range
  always_ff @(posedge clk) begin
    if (!reset) begin
      assert ($onehot0(o_flr_pos));
      assert (!o_door_open || $onehot(o_flr_pos));
      assert (int'(o_floor_idx) < N_FLOORS);
    end
  end
endmodule

// File: doc/lift_car_sequencer.md
Name: lift_car_sequencer

Overview:
Car-side sequencer that closes the loop with the lift decision logic. It consumes the motion, direction and stop-request decisions and generates the registered floor-position one-hot and door-open level that the decision logic consumes. Travel between floors and door dwell are timed, so the controller sees realistic in-transit (all-zero position) intervals and a door-closing falling edge.

Parameters:
N_FLOORS, 8, number of floors; must be >= 2.
TRAVEL_CYCLES, 16, cycles spent between adjacent floors with o_flr_pos = 0; must be >= 1.
DOOR_OPEN_CYCLES, 32, door dwell in cycles with no hold; must be >= 1.
CLOSE_GUARD_CYCLES, 4, post-close cycles during which inputs are ignored; must be >= 4 to cover the 4-cycle request-clear pulse.

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
i_motion  input  1  move request from the decision logic
i_direction  input  1  1 = up, 0 = down; sampled at departure
i_has_rqst_at_stopped_flr  input  1  open the door at the current floor
i_door_hold  input  1  door-open button; extends dwell
o_flr_pos  output  N_FLOORS  one-hot current floor; all-zero while in transit
o_door_open  output  1  door open level
o_floor_idx  output  $clog2(N_FLOORS)  binary index of the last floor reached
o_limit_err  output  1  one-cycle pulse on a move request beyond the top or bottom floor

Behaviour:
- Clock is clk. Reset is reset: synchronous, active-high.
- All outputs are registered.
- Reset values: state PARKED, floor 0, o_flr_pos = 1 (bit 0), o_door_open = 0, o_floor_idx = 0, o_limit_err = 0, timers = 0.
- Reset asserted mid-travel or mid-door forces the reset values on the next edge. The car returns home; nothing is retained.
- A single down-counter is shared by all states. Its width is $clog2 of the largest timing parameter, plus 1.

States:
- PARKED
  - o_flr_pos = onehot(floor), o_door_open = 0.
  - Priority 1: i_has_rqst_at_stopped_flr = 1 -> DOOR_OPEN; timer = DOOR_OPEN_CYCLES-1.
  - Priority 2: i_motion = 1 with a legal direction -> TRAVEL; timer = TRAVEL_CYCLES-1; latch i_direction.
  - Illegal move (up at floor N-1, or down at floor 0): stay PARKED and pulse o_limit_err for one cycle. The pulse repeats every cycle the illegal request persists.
  - Door request and motion asserted together: the door wins.
- TRAVEL
  - o_flr_pos = 0 for exactly TRAVEL_CYCLES cycles.
  - All inputs are ignored, and direction uses the latched value.
  - On timer == 0: floor = floor +/- 1, o_floor_idx updates, state -> PARKED.
  - A held i_motion causes one PARKED cycle per hop, so each hop takes TRAVEL_CYCLES+1 cycles.
- DOOR_OPEN
  - o_door_open = 1; o_flr_pos stays one-hot.
  - i_door_hold = 1 reloads timer to DOOR_OPEN_CYCLES-1.
  - Otherwise, on timer == 0 -> CLOSE_GUARD with timer = CLOSE_GUARD_CYCLES-1; otherwise decrement.
  - With no hold, the door is open exactly DOOR_OPEN_CYCLES cycles. With hold, it closes DOOR_OPEN_CYCLES cycles after the last cycle hold was high.
- CLOSE_GUARD
  - o_door_open = 0; the 1->0 edge on entry is the door-close event.
  - All inputs are ignored for CLOSE_GUARD_CYCLES cycles.
  - On timer == 0 -> PARKED.
  - There is no reopen during the guard. A new stop request is serviced from PARKED afterwards.

Invariants (assertions):
- o_flr_pos is one-hot or all-zero.
- o_door_open = 1 implies o_flr_pos is one-hot.
- o_flr_pos = 0 implies o_door_open = 0.
- floor never leaves 0..N_FLOORS-1.

Test Plan:
Parameters for all scenarios: N_FLOORS = 4, TRAVEL_CYCLES = 3, DOOR_OPEN_CYCLES = 5, CLOSE_GUARD_CYCLES = 4.
1. Reset held 2 cycles, then released with all inputs 0 -> o_flr_pos = 4'b0001, o_door_open = 0, o_floor_idx = 0; values hold indefinitely.
2. At floor 0, i_motion = 1 and i_direction = 1 held -> o_flr_pos = 0000 for 3 cycles, 0010 for 1 cycle, 0000 for 3 cycles, then 0100; o_floor_idx goes 1 then 2. Flipping i_direction mid-hop has no effect.
3. At floor 1, i_has_rqst_at_stopped_flr pulsed 1 cycle, and i_motion = 1 asserted from the door's 5th open cycle -> o_door_open = 1 for exactly 5 cycles, then 0 for 4 guard cycles with o_flr_pos = 0010 throughout; o_flr_pos = 0000 begins on the 2nd cycle after the guard ends.
4. DOOR_OPEN entered with i_door_hold = 1 during open cycles 2-4 -> o_door_open = 1 for 9 cycles total, then the guard follows.
5. At floor 3, i_motion = 1 and i_direction = 1 for 3 cycles -> o_limit_err high for 3 cycles, o_flr_pos stays 1000. Same check at floor 0 with i_direction = 0.
6. Reset asserted on the 2nd TRAVEL cycle between floors 1 and 2, and separately during DOOR_OPEN -> next cycle o_flr_pos = 0001, o_door_open = 0, o_floor_idx = 0, state PARKED.
